icache_dm: RTL and testbench

//  Parametrised direct-mapped instruction cache; successor to the single-line fully-associative cache.

---
 rtl/cache_pkg.sv | 12 +
 rtl/icache_word_sel.sv | 24 ++
 rtl/icache_dm.sv | 179 +++++++++++++++++
 tb/tb_icache_dm.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: word width and
// the refill FSM state encoding.
package cache_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_FILL   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/icache_word_sel.sv
// Selects one 32-bit word out of a cache line by word offset; word 0 lives in
// the least significant bits of the line.
module icache_word_sel
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = 16,
    parameter int SEL_W      = $clog2(LINE_WORDS)
) (
    input  logic [LINE_WORDS*WORD_W-1:0] line_i,
    input  logic [SEL_W-1:0]             sel_i,
    output logic [WORD_W-1:0]            word_o
);

    logic [WORD_W-1:0] words [LINE_WORDS];

    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_split
            assign words[gi] = line_i[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign word_o = words[sel_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with a req/ack line-fill port,
// whole-cache flush and wrapping hit/miss statistics counters.
module icache_dm
    import cache_pkg::*;
#(
    parameter int NUM_LINES  = 8,
    parameter int LINE_WORDS = 16,
    parameter int CNT_W      = 32
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         cpu_req,
    input  logic [31:0]                  cpu_addr,
    output logic                         cpu_ready,
    output logic [31:0]                  inst,
    output logic                         inst_valid,
    output logic                         hit,
    output logic                         miss,
    input  logic                         flush,
    output logic                         mem_req,
    output logic [31:0]                  mem_addr,
    input  logic                         mem_ack,
    input  logic [LINE_WORDS*WORD_W-1:0] mem_block,
    output logic [CNT_W-1:0]             hit_count,
    output logic [CNT_W-1:0]             miss_count
);

    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int SEL_W  = OFF_W - 2;
    localparam int LINE_W = LINE_WORDS * WORD_W;

    logic [1:0]           state_q, state_d;
    logic [31:2]          addr_q, addr_d;
    logic [WORD_W-1:0]    inst_q, inst_d;
    logic                 hit_q, hit_d;
    logic                 mem_req_q, mem_req_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic                 flushed_q, flushed_d;

    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [LINE_W-1:0]    data_arr [NUM_LINES];

    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [SEL_W-1:0]     req_woff;
    logic                 lookup_hit;
    logic                 fill_we;
    logic [WORD_W-1:0]    cached_word;
    logic [WORD_W-1:0]    fill_word;
    logic                 unused_addr_bits;

    assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

    assign req_idx    = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign req_tag    = addr_q[31:OFF_W+IDX_W];
    assign req_woff   = addr_q[OFF_W-1:2];
    assign lookup_hit = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);

    icache_word_sel #(.LINE_WORDS(LINE_WORDS), .SEL_W(SEL_W)) u_sel_cache (
        .line_i (data_arr[req_idx]),
        .sel_i  (req_woff),
        .word_o (cached_word)
    );

    icache_word_sel #(.LINE_WORDS(LINE_WORDS), .SEL_W(SEL_W)) u_sel_fill (
        .line_i (mem_block),
        .sel_i  (req_woff),
        .word_o (fill_word)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        hit_d      = hit_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        valid_d    = valid_q;
        flushed_d  = flushed_q;
        fill_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr[31:2];
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (lookup_hit) begin
                    inst_d    = cached_word;
                    hit_d     = 1'b1;
                    hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    state_d   = ST_RESP;
                end else begin
                    hit_d      = 1'b0;
                    miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    mem_req_d  = 1'b1;
                    mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
                    flushed_d  = 1'b0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                // Remember a flush seen at any point of the fill so the line stays invalid.
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (mem_ack) begin
                    fill_we   = 1'b1;
                    inst_d    = fill_word;
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            valid_d = '0;
        end else if (fill_we && !flushed_q) begin
            valid_d[req_idx] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            inst_q     <= '0;
            hit_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '0;
            flushed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inst_q     <= inst_d;
            hit_q      <= hit_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
            flushed_q  <= flushed_d;
        end
    end

    // Tag/data storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst && fill_we) begin
            tag_arr[req_idx]  <= req_tag;
            data_arr[req_idx] <= mem_block;
        end
    end

    assign cpu_ready  = (state_q == ST_IDLE);
    assign inst_valid = (state_q == ST_RESP);
    assign hit        = inst_valid && hit_q;
    assign miss       = (state_q == ST_LOOKUP) && !lookup_hit;
    assign inst       = inst_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus randomized reads
// compared against an address-arithmetic model of a direct-mapped cache.
module tb_icache_dm;

    localparam int NL = 8;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            sys_rst;
    logic            cpu_req;
    logic [31:0]     cpu_addr;
    logic            cpu_ready;
    logic [31:0]     inst;
    logic            inst_valid;
    logic            hit;
    logic            miss;
    logic            flush;
    logic            mem_req;
    logic [31:0]     mem_addr;
    logic            mem_ack;
    logic [LW*32-1:0] mem_block;
    logic [31:0]     hit_count;
    logic [31:0]     miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          ref_valid [NL];
    logic [31:0] ref_tag   [NL];
    int          ref_hits;
    int          ref_misses;

    // Observations from the last do_read
    logic [31:0] r_inst;
    bit          r_hit;
    int          r_miss;
    bit          r_memreq;
    logic [31:0] r_memaddr;
    int          r_lat;
    bit          r_bad;

    always #5 clk = ~clk;

    icache_dm #(.NUM_LINES(NL), .LINE_WORDS(LW), .CNT_W(32)) dut (
        .sys_clk    (clk),
        .sys_rst    (sys_rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .inst       (inst),
        .inst_valid (inst_valid),
        .hit        (hit),
        .miss       (miss),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_block  (mem_block),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // Backing ROM contents: word at 0x40+4k is 0x1000+k; higher tags scrambled.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (32'h0000_0FF0 + (a >> 2)) ^ ((a >> 9) << 20);
    endfunction

    function automatic logic [LW*32-1:0] make_block(input logic [31:0] line);
        logic [LW*32-1:0] b;
        for (int k = 0; k < LW; k++) b[k*32 +: 32] = mem_word(line + 32'(k * 4));
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
        ref_hits = 0;
        ref_misses = 0;
    endtask

    // fmode: 0 none, 1 flush together with the request, 2 flush on the mem_ack cycle
    task automatic model_access(input logic [31:0] a, input int fmode, output bit h);
        int idx;
        logic [31:0] tg;
        idx = int'((a >> 6) % NL);
        tg  = a >> 9;
        if (fmode == 1) for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
        h = ref_valid[idx] && (ref_tag[idx] == tg);
        if (h) begin
            ref_hits++;
        end else begin
            ref_misses++;
            if (fmode == 2) begin
                for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
            end else begin
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
            end
        end
    endtask

    // Issue one fetch, serve the fill with 'delay' wait cycles, record what was seen.
    task automatic do_read(input logic [31:0] a, input int delay, input int fmode);
        int guard, cyc, waited;
        logic [31:0] inst_prev;
        bit got;
        r_inst = '0; r_hit = 0; r_miss = 0; r_memreq = 0; r_memaddr = '0; r_lat = 0; r_bad = 0;
        got = 0;
        guard = 0;
        while (!cpu_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        inst_prev = inst;
        cpu_req  = 1'b1;
        cpu_addr = a;
        if (fmode == 1) flush = 1'b1;
        @(negedge clk);
        cpu_req  = 1'b0;
        flush    = 1'b0;
        cpu_addr = $urandom;
        cyc = 1;
        waited = 0;
        while (cyc < 200) begin
            if (miss) r_miss++;
            if (cpu_ready) r_bad = 1;
            if (hit && !inst_valid) r_bad = 1;
            if (!inst_valid && inst !== inst_prev) r_bad = 1;
            if (mem_req) begin
                if (!r_memreq) begin
                    r_memreq  = 1;
                    r_memaddr = mem_addr;
                end else if (mem_addr !== r_memaddr) begin
                    r_bad = 1;
                end
                if (waited > delay) r_bad = 1;
                if (waited == delay) begin
                    mem_ack   = 1'b1;
                    mem_block = make_block(mem_addr);
                    if (fmode == 2) flush = 1'b1;
                end
                waited++;
            end
            if (inst_valid) begin
                got    = 1;
                r_inst = inst;
                r_hit  = hit;
                r_lat  = cyc;
                break;
            end
            @(negedge clk);
            mem_ack   = 1'b0;
            flush     = 1'b0;
            mem_block = {LW{$urandom}};
            cyc++;
        end
        mem_ack = 1'b0;
        flush   = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout addr=%h: no inst_valid within 200 cycles", a);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        n_checks++;
        if ({cpu_ready, inst_valid, hit, miss, mem_req} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl got rdy/iv/hit/miss/req=%b want 10000",
                     {cpu_ready, inst_valid, hit, miss, mem_req});
        end
        n_checks++;
        if ({mem_addr, inst, hit_count, miss_count} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data got addr=%h inst=%h hc=%0d mc=%0d want all 0",
                     mem_addr, inst, hit_count, miss_count);
        end
        sys_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_miss_fill();
        bit h;
        model_access(32'h40, 0, h);
        do_read(32'h40, 1, 0);
        n_checks++;
        if (r_miss !== 1 || r_memreq !== 1'b1 || r_memaddr !== 32'h40) begin
            n_fail++;
            $display("FAIL miss_fill_req got miss=%0d req=%b addr=%h want 1 1 00000040",
                     r_miss, r_memreq, r_memaddr);
        end
        n_checks++;
        if (r_inst !== 32'h1000 || r_hit !== 1'b0 || r_bad) begin
            n_fail++;
            $display("FAIL miss_fill_resp got inst=%h hit=%b bad=%b want 00001000 0 0",
                     r_inst, r_hit, r_bad);
        end
        n_checks++;
        if (miss_count !== 32'd1 || r_lat !== 4) begin
            n_fail++;
            $display("FAIL miss_fill_cnt got mc=%0d lat=%0d want 1 4", miss_count, r_lat);
        end
    endtask

    task automatic test_hit();
        bit h;
        model_access(32'h48, 0, h);
        do_read(32'h48, 0, 0);
        n_checks++;
        if (r_inst !== 32'h1002 || r_hit !== 1'b1 || r_lat !== 2) begin
            n_fail++;
            $display("FAIL hit_resp got inst=%h hit=%b lat=%0d want 00001002 1 2", r_inst, r_hit, r_lat);
        end
        n_checks++;
        if (r_memreq !== 1'b0 || r_miss !== 0 || hit_count !== 32'd1) begin
            n_fail++;
            $display("FAIL hit_side got req=%b miss=%0d hc=%0d want 0 0 1", r_memreq, r_miss, hit_count);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] seq [3];
        bit h;
        seq[0] = 32'h40; seq[1] = 32'h240; seq[2] = 32'h40;
        for (int i = 0; i < 3; i++) begin
            model_access(seq[i], (i == 0) ? 1 : 0, h);
            do_read(seq[i], 0, (i == 0) ? 1 : 0);
            n_checks++;
            if (r_hit !== 1'b0 || r_miss !== 1 || r_inst !== mem_word(seq[i]) || h) begin
                n_fail++;
                $display("FAIL conflict_%0d got hit=%b miss=%0d inst=%h want 0 1 %h",
                         i, r_hit, r_miss, r_inst, mem_word(seq[i]));
            end
        end
    endtask

    task automatic test_flush_on_ack();
        bit h;
        model_access(32'h80, 2, h);
        do_read(32'h80, 2, 2);
        n_checks++;
        if (r_inst !== 32'h1010 || r_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ack_resp got inst=%h hit=%b want 00001010 0", r_inst, r_hit);
        end
        model_access(32'h80, 0, h);
        do_read(32'h80, 0, 0);
        n_checks++;
        if (r_hit !== 1'b0 || r_miss !== 1 || r_memaddr !== 32'h80) begin
            n_fail++;
            $display("FAIL flush_ack_reread got hit=%b miss=%0d addr=%h want 0 1 00000080",
                     r_hit, r_miss, r_memaddr);
        end
    endtask

    task automatic test_slow_ack();
        bit h;
        model_access(32'h104, 0, h);
        do_read(32'h104, 20, 0);
        n_checks++;
        if (r_bad || r_lat !== 23 || r_memaddr !== 32'h100 || r_inst !== mem_word(32'h104)) begin
            n_fail++;
            $display("FAIL slow_ack got bad=%b lat=%0d addr=%h inst=%h want 0 23 00000100 %h",
                     r_bad, r_lat, r_memaddr, r_inst, mem_word(32'h104));
        end
    endtask

    task automatic test_reset_mid_fill();
        bit h;
        int guard;
        cpu_req = 1'b1;
        cpu_addr = 32'h3C0;
        @(negedge clk);
        cpu_req = 1'b0;
        guard = 0;
        while (!mem_req && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);
        sys_rst = 1'b1;
        model_reset();
        n_checks++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b1 || hit_count !== 0 || miss_count !== 0 || inst !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_fill got req=%b rdy=%b hc=%0d mc=%0d inst=%h want 0 1 0 0 0",
                     mem_req, cpu_ready, hit_count, miss_count, inst);
        end
        mem_ack = 1'b1;
        mem_block = make_block(32'h3C0);
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++;
        if (cpu_ready !== 1'b1 || inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack got rdy=%b iv=%b req=%b want 1 0 0", cpu_ready, inst_valid, mem_req);
        end
        model_access(32'h3C0, 0, h);
        do_read(32'h3C0, 0, 0);
        n_checks++;
        if (r_hit !== 1'b0 || r_miss !== 1) begin
            n_fail++;
            $display("FAIL late_ack_nofill got hit=%b miss=%0d want 0 1", r_hit, r_miss);
        end
        model_access(32'h40, 0, h);
        do_read(32'h40, 0, 0);
        n_checks++;
        if (r_hit !== 1'b0 || r_miss !== 1 || r_inst !== 32'h1000) begin
            n_fail++;
            $display("FAIL rst_reread got hit=%b miss=%0d inst=%h want 0 1 00001000", r_hit, r_miss, r_inst);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int delay, fmode, r, exp_lat;
        bit h;
        for (int t = 0; t < 60; t++) begin
            a = ($urandom_range(0, 2) << 9) | ($urandom_range(0, NL - 1) << 6) | ($urandom_range(0, LW - 1) << 2);
            delay = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            fmode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            model_access(a, fmode, h);
            do_read(a, delay, fmode);
            exp_lat = h ? 2 : 3 + delay;
            n_checks++;
            if (r_inst !== mem_word(a) || r_hit !== h || r_lat !== exp_lat || r_bad) begin
                n_fail++;
                $display("FAIL rand_%0d addr=%h got inst=%h hit=%b lat=%0d bad=%b want %h %b %0d 0",
                         t, a, r_inst, r_hit, r_lat, r_bad, mem_word(a), h, exp_lat);
            end
            n_checks++;
            if (r_miss !== (h ? 0 : 1) || r_memreq !== !h || (!h && r_memaddr !== (a & ~32'h3F))) begin
                n_fail++;
                $display("FAIL rand_fill_%0d addr=%h got miss=%0d req=%b maddr=%h want %0d %b %h",
                         t, a, r_miss, r_memreq, r_memaddr, h ? 0 : 1, !h, a & ~32'h3F);
            end
        end
        n_checks++;
        if (hit_count !== 32'(ref_hits) || miss_count !== 32'(ref_misses)) begin
            n_fail++;
            $display("FAIL counters got hc=%0d mc=%0d want %0d %0d", hit_count, miss_count, ref_hits, ref_misses);
        end
    endtask

    initial begin
        sys_rst   = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_block = '0;
        @(negedge clk);
        test_reset();
        test_miss_fill();
        test_hit();
        test_conflict();
        test_flush_on_ack();
        test_slow_ack();
        test_reset_mid_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
